wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter. It shares the SoC bus between core0 (M0) and a second bus master (M1, the debug/DMA port).
- It sits between the masters and the existing address decode that feeds ram0 and the UART at 32'hffff.
- Round-robin grant, held for the whole CYC. A bus watchdog converts a hung slave access into ERR.

Parameters:
- DW, 32, data bus width.
- AW, 32, address bus width.
- TIMEOUT, 256, cycles STB may stay unanswered before ERR; 0 disables the watchdog.
- CW, 9, watchdog counter width; must satisfy 2**CW > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- m0_cyc, m1_cyc  in  1  master cycle requests.
- m0_stb, m1_stb  in  1  master strobes.
- m0_we, m1_we  in  1  master write enables.
- m0_adr, m1_adr  in  AW  master addresses.
- m0_dat_w, m1_dat_w  in  DW  master write data.
- m0_cti, m1_cti  in  3  master cycle type identifiers.
- m0_dat_r, m1_dat_r  out  DW  read data returned to each master.
- m0_ack, m1_ack  out  1  acknowledge to each master.
- m0_err, m1_err  out  1  error to each master (slave ERR or watchdog).
- m0_rty, m1_rty  out  1  retry to each master.
- s_cyc, s_stb, s_we  out  1  slave-side cycle, strobe and write enable.
- s_adr  out  AW  slave address.
- s_dat_w  out  DW  slave write data.
- s_cti  out  3  slave cycle type identifier.
- s_dat_r  in  DW  slave read data.
- s_ack, s_err, s_rty  in  1  slave responses.
- gnt  out  2  current grant, one-hot: 01 = M0, 10 = M1, 00 = idle.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, gnt = 00, last = M1 (so M0 wins the first tie).
  - watchdog counter = 0.
  - All slave-side outputs and all master response outputs 0; dat buses 0.
- States:
  - IDLE: no grant. Every s_* output is 0.
    - Only one mN_cyc high: grant it next edge (GNT0/GNT1).
    - Both high: grant the master not equal to last.
  - GNT0 / GNT1: the granted master's cyc/stb/we/adr/dat_w/cti drive s_* combinationally.
    - s_dat_r/s_ack/s_err/s_rty route combinationally to that master only.
    - Arbitration latency: 1 cycle from mN_cyc rise to s_cyc rise. No arbitration inside a grant; CYC acts as the bus lock.
- Release: sampled at posedge when the granted master's cyc = 0.
  - last <= that master.
  - Other master's cyc = 1: switch directly to its grant (no IDLE cycle).
  - Otherwise go to IDLE.
  - s_cyc is therefore low for at least the release cycle.
- Ungranted master: ack/err/rty = 0 and dat_r = 0 at all times. Its stb is ignored; it waits.
- Watchdog, when TIMEOUT != 0:
  - Counter increments each cycle s_cyc & s_stb & ~(s_ack|s_err|s_rty).
  - Counter clears on any response, when stb drops, and on grant change.
  - When the counter equals TIMEOUT-1 and no slave response arrives that cycle:
    - Assert err to the granted master for exactly 1 cycle.
    - Force s_stb = 0 that cycle.
    - Clear the counter.
  - The master must then drop or restart the transfer.
- Simultaneous slave response and watchdog expiry: the slave response wins; no watchdog err.
- Burst (cti != 000/111): grant is still held by CYC only; the arbiter does not inspect cti beyond passing it through.
- Master drops cyc while stb is pending: the access is abandoned; the slave sees s_cyc fall the same cycle (combinational).
- Reset mid-transfer: immediate IDLE. No response is delivered to either master.
- gnt is registered and equals the state encoding.

Test Plan:
- Reset, then m0_cyc=m0_stb=1, adr=32'h10, we=0; slave returns ack with dat_r=32'hdeadbeef one cycle after s_stb -> s_cyc rises 1 cycle after m0_cyc; gnt=01; m0_ack=1 and m0_dat_r=32'hdeadbeef; m1 outputs stay 0.
- Both masters raise cyc in the same cycle after reset -> M0 granted first. M0 releases while M1 still requesting -> gnt goes 01 to 10 on the next edge with no IDLE cycle. Repeat the tie -> M1 is not granted twice in a row; M0 gets the next tie.
- M0 holds cyc across 4 back-to-back acked writes while m1_cyc=1 throughout -> gnt stays 01 for all 4; M1 is granted only after m0_cyc falls.
- TIMEOUT=8, M1 writes adr=32'hffff0 and the slave never responds -> m1_err=1 for exactly 1 cycle, 8 cycles after s_stb rose; s_stb=0 that cycle. With TIMEOUT=0 there is no err after 1000 cycles.
- TIMEOUT=8, slave ack arrives in the 8th stalled cycle -> m0_ack=1 and m0_err=0.
- rst pulled low mid-transfer while gnt=10 -> all outputs 0 and gnt=00 asynchronously. After release, a pending m0/m1 tie grants M0.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Two-master / one-slave Wishbone arbiter with round-robin grant
//            held for the whole CYC, plus a bus watchdog that turns a hung
//            slave access into ERR.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 256,
    parameter int CW      = 9
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_w,
    input  logic [2:0]    m0_cti,
    output logic [DW-1:0] m0_dat_r,
    output logic          m0_ack,
    output logic          m0_err,
    output logic          m0_rty,

    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_w,
    input  logic [2:0]    m1_cti,
    output logic [DW-1:0] m1_dat_r,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          m1_rty,

    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_w,
    output logic [2:0]    s_cti,
    input  logic [DW-1:0] s_dat_r,
    input  logic          s_ack,
    input  logic          s_err,
    input  logic          s_rty,

    output logic [1:0]    gnt
);

    localparam logic [1:0] c_idle = 2'b00;
    localparam logic [1:0] c_gnt0 = 2'b01;
    localparam logic [1:0] c_gnt1 = 2'b10;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_last;          // 0: M0 owned the bus last, 1: M1
    logic          w_last_nxt;
    logic          w_sel0;
    logic          w_sel1;
    logic          w_cyc;
    logic          w_stb;
    logic          w_we;
    logic [AW-1:0] w_adr;
    logic [DW-1:0] w_dat_w;
    logic [2:0]    w_cti;
    logic          w_timeout;

    assign w_sel0 = (r_state == c_gnt0);
    assign w_sel1 = (r_state == c_gnt1);

    // Grant is only re-evaluated when the owner drops CYC; a waiting master
    // is handed the bus on that same edge without passing through idle.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            c_idle: begin
                if (m0_cyc && m1_cyc) begin
                    w_state_nxt = r_last ? c_gnt0 : c_gnt1;
                end else if (m0_cyc) begin
                    w_state_nxt = c_gnt0;
                end else if (m1_cyc) begin
                    w_state_nxt = c_gnt1;
                end
            end
            c_gnt0: begin
                if (!m0_cyc) begin
                    w_last_nxt  = 1'b0;
                    w_state_nxt = m1_cyc ? c_gnt1 : c_idle;
                end
            end
            c_gnt1: begin
                if (!m1_cyc) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = m0_cyc ? c_gnt0 : c_idle;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_idle;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign gnt = r_state;

    always_comb begin
        w_cyc   = 1'b0;
        w_stb   = 1'b0;
        w_we    = 1'b0;
        w_adr   = '0;
        w_dat_w = '0;
        w_cti   = 3'b000;
        if (w_sel0) begin
            w_cyc   = m0_cyc;
            w_stb   = m0_stb;
            w_we    = m0_we;
            w_adr   = m0_adr;
            w_dat_w = m0_dat_w;
            w_cti   = m0_cti;
        end else if (w_sel1) begin
            w_cyc   = m1_cyc;
            w_stb   = m1_stb;
            w_we    = m1_we;
            w_adr   = m1_adr;
            w_dat_w = m1_dat_w;
            w_cti   = m1_cti;
        end
    end

    generate
        if (TIMEOUT != 0) begin : g_wdt
            localparam logic [CW-1:0] c_wdt_last = CW'(TIMEOUT - 1);

            logic [CW-1:0] r_wdt;
            logic          w_resp;
            logic          w_stalled;

            assign w_resp    = s_ack | s_err | s_rty;
            assign w_stalled = w_cyc & w_stb & ~w_resp;
            // A slave response in the expiry cycle beats the watchdog.
            assign w_timeout = w_stalled & (r_wdt == c_wdt_last);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_wdt <= '0;
                end else if ((w_state_nxt != r_state) || !w_stalled || w_timeout) begin
                    r_wdt <= '0;
                end else begin
                    r_wdt <= r_wdt + CW'(1);
                end
            end
        end else begin : g_no_wdt
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign s_cyc   = w_cyc;
    assign s_stb   = w_cyc & w_stb & ~w_timeout;
    assign s_we    = w_we;
    assign s_adr   = w_adr;
    assign s_dat_w = w_dat_w;
    assign s_cti   = w_cti;

    assign m0_ack   = w_sel0 & s_ack;
    assign m0_err   = w_sel0 & (s_err | w_timeout);
    assign m0_rty   = w_sel0 & s_rty;
    assign m0_dat_r = w_sel0 ? s_dat_r : '0;

    assign m1_ack   = w_sel1 & s_ack;
    assign m1_err   = w_sel1 & (s_err | w_timeout);
    assign m1_rty   = w_sel1 & s_rty;
    assign m1_dat_r = w_sel1 ? s_dat_r : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed and randomized self-checking bench for wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_dat_w;
    logic [2:0]  m0_cti;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_dat_w;
    logic [2:0]  m1_cti;
    logic [31:0] s_dat_r;
    logic        s_ack, s_err, s_rty;

    logic [31:0] m0_dat_r, m1_dat_r, s_adr, s_dat_w;
    logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic        s_cyc, s_stb, s_we;
    logic [2:0]  s_cti;
    logic [1:0]  gnt;

    logic [31:0] z_m0_dat_r, z_m1_dat_r, z_s_adr, z_s_dat_w;
    logic        z_m0_ack, z_m0_err, z_m0_rty, z_m1_ack, z_m1_err, z_m1_rty;
    logic        z_s_cyc, z_s_stb, z_s_we;
    logic [2:0]  z_s_cti;
    logic [1:0]  z_gnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DW(32), .AW(32), .TIMEOUT(TMO), .CW(9)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_cti(m0_cti), .m0_dat_r(m0_dat_r),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_cti(m1_cti), .m1_dat_r(m1_dat_r),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_cti(s_cti), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .gnt(gnt)
    );

    // Same inputs, watchdog disabled.
    wb_arbiter #(.DW(32), .AW(32), .TIMEOUT(0), .CW(9)) dut_nowdt (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_cti(m0_cti), .m0_dat_r(z_m0_dat_r),
        .m0_ack(z_m0_ack), .m0_err(z_m0_err), .m0_rty(z_m0_rty),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_cti(m1_cti), .m1_dat_r(z_m1_dat_r),
        .m1_ack(z_m1_ack), .m1_err(z_m1_err), .m1_rty(z_m1_rty),
        .s_cyc(z_s_cyc), .s_stb(z_s_stb), .s_we(z_s_we), .s_adr(z_s_adr),
        .s_dat_w(z_s_dat_w), .s_cti(z_s_cti), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .gnt(z_gnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat_w = '0; m0_cti = 3'b000;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_dat_w = '0; m1_cti = 3'b000;
        s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic pulse_reset;
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    // Reference model state: who owns the bus (-1 none), who owned it
    // last, and how many cycles the current strobe has gone unanswered.
    int          owner, last_owner, nxt_owner, stall;
    logic        gcyc, gstb, gwe, resp, tmo;
    logic [31:0] gadr, gdat, d;
    logic [2:0]  gcti;
    logic [1:0]  egnt;
    logic [13:0] exp_ctrl;
    int          err_cnt;
    logic        z_seen;

    initial begin
        rst = 1'b0;
        clear_inputs();
        #2;
        check("rst_ctrl", {gnt, s_cyc, s_stb, s_we, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, '0);
        check("rst_bus", {s_adr, s_dat_w}, '0);
        step(); step();
        rst = 1'b1;

        // Single read by M0
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h10; m0_we = 1'b0;
        #1;
        check("lat_pre", {gnt, s_cyc}, 3'b000);
        step();
        check("lat_gnt", {gnt, s_cyc, s_stb}, 4'b0111);
        check("rd_adr", s_adr, 32'h10);
        step();
        s_ack = 1'b1; s_dat_r = 32'hdeadbeef;
        #1;
        check("rd_ack", {m0_ack, m0_dat_r}, {1'b1, 32'hdeadbeef});
        check("rd_m1_quiet", {m1_ack, m1_err, m1_rty, m1_dat_r}, '0);
        step();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        #1;
        check("rel_cycle", {gnt, s_cyc}, 3'b010);
        step();
        check("rel_idle", gnt, 2'b00);

        // Round-robin ties
        pulse_reset();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        step();
        check("rr_first", gnt, 2'b01);
        m0_cyc = 1'b0;
        #1;
        check("rr_rel", {gnt, s_cyc}, 3'b010);
        step();
        check("rr_noidle", gnt, 2'b10);
        m1_cyc = 1'b0;
        step();
        check("rr_idle1", gnt, 2'b00);
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        step();
        check("rr_tie_m0", gnt, 2'b01);
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        step();
        check("rr_idle2", gnt, 2'b00);
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        step();
        check("rr_tie_m1", gnt, 2'b10);
        m1_cyc = 1'b0;
        step();
        m1_cyc = 1'b1;
        #1;
        check("bb_start", gnt, 2'b01);

        // Back-to-back writes by M0 with M1 waiting
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h100 + 32'(i); m0_dat_w = d; s_ack = 1'b1;
            #1;
            check("bb_gnt", gnt, 2'b01);
            check("bb_dat", {s_we, s_adr, s_dat_w}, {1'b1, 32'h100 + 32'(i), d});
            check("bb_ack", {m0_ack, m1_ack}, 2'b10);
            step();
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; s_ack = 1'b0;
        #1;
        check("bb_hold", gnt, 2'b01);
        step();
        check("bb_m1_after", gnt, 2'b10);
        m1_cyc = 1'b0;
        step();

        // Watchdog: M1 write to a slave that never answers
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'hffff0; m1_dat_w = 32'h55;
        step();
        for (int k = 1; k < TMO; k++) begin
            check("wdt_quiet", {m1_err, s_stb}, 2'b01);
            step();
        end
        check("wdt_fire", {m1_err, s_stb, m0_err}, 3'b100);
        check("wdt_off_fire", {z_m1_err, z_s_stb}, 2'b01);
        step();
        check("wdt_once", {m1_err, s_stb}, 2'b01);
        err_cnt = 0;
        z_seen  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (m1_err) err_cnt++;
            if (z_m1_err) z_seen = 1'b1;
            step();
        end
        check("wdt_period", 32'(err_cnt), 32'd125);
        check("wdt_off_1000", z_seen, 1'b0);
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        step();

        // Ack in the expiry cycle wins over the watchdog
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h20;
        step();
        for (int k = 1; k < TMO; k++) begin
            check("ack8_pre", m0_err, 1'b0);
            step();
        end
        s_ack = 1'b1; s_dat_r = 32'h5a5a;
        #1;
        check("ack8", {m0_ack, m0_err, s_stb}, 3'b101);
        step();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        step();

        // Asynchronous reset while M1 holds the bus
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h1234; m1_dat_w = 32'habcd;
        step();
        s_ack = 1'b1; s_dat_r = 32'h77;
        #1;
        check("mid_pre", {gnt, m1_ack}, 3'b101);
        m0_cyc = 1'b1;
        rst = 1'b0;
        #1;
        check("mid_ctrl", {gnt, s_cyc, s_stb, s_we, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, '0);
        check("mid_bus", {s_adr, s_dat_w}, '0);
        check("mid_rdat", {m0_dat_r, m1_dat_r}, '0);
        rst = 1'b1; s_ack = 1'b0;
        step();
        check("mid_tie_m0", gnt, 2'b01);

        // Randomized traffic against the reference model
        clear_inputs();
        step();
        pulse_reset();
        owner = -1; last_owner = 1; stall = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(0, 5) == 0) m1_cyc = ~m1_cyc;
            m0_stb = ($urandom_range(0, 3) != 0); m0_we = 1'($urandom);
            m0_adr = $urandom; m0_dat_w = $urandom; m0_cti = 3'($urandom);
            m1_stb = ($urandom_range(0, 3) != 0); m1_we = 1'($urandom);
            m1_adr = $urandom; m1_dat_w = $urandom; m1_cti = 3'($urandom);
            s_dat_r = $urandom;
            s_ack = ($urandom_range(0, 9) == 0);
            s_err = ($urandom_range(0, 39) == 0);
            s_rty = ($urandom_range(0, 39) == 0);
            #1;
            gcyc = 1'b0; gstb = 1'b0; gwe = 1'b0; gadr = '0; gdat = '0; gcti = 3'b000; egnt = 2'b00;
            if (owner == 0) begin
                gcyc = m0_cyc; gstb = m0_stb; gwe = m0_we; gadr = m0_adr; gdat = m0_dat_w; gcti = m0_cti; egnt = 2'b01;
            end else if (owner == 1) begin
                gcyc = m1_cyc; gstb = m1_stb; gwe = m1_we; gadr = m1_adr; gdat = m1_dat_w; gcti = m1_cti; egnt = 2'b10;
            end
            resp = s_ack | s_err | s_rty;
            tmo  = gcyc && gstb && !resp && (stall == TMO - 1);
            exp_ctrl = {egnt, gcyc, gcyc & gstb & ~tmo, gwe, gcti,
                        (owner == 0) & s_ack, (owner == 0) & (s_err | tmo), (owner == 0) & s_rty,
                        (owner == 1) & s_ack, (owner == 1) & (s_err | tmo), (owner == 1) & s_rty};
            check("rnd_ctrl", {gnt, s_cyc, s_stb, s_we, s_cti, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, exp_ctrl);
            check("rnd_bus", {s_adr, s_dat_w}, {gadr, gdat});
            check("rnd_rdat", {m0_dat_r, m1_dat_r},
                  {(owner == 0) ? s_dat_r : 32'h0, (owner == 1) ? s_dat_r : 32'h0});
            @(posedge clk);
            nxt_owner = owner;
            if (owner == -1) begin
                if (m0_cyc && m1_cyc) nxt_owner = (last_owner == 1) ? 0 : 1;
                else if (m0_cyc) nxt_owner = 0;
                else if (m1_cyc) nxt_owner = 1;
            end else if (owner == 0 && !m0_cyc) begin
                last_owner = 0;
                nxt_owner  = m1_cyc ? 1 : -1;
            end else if (owner == 1 && !m1_cyc) begin
                last_owner = 1;
                nxt_owner  = m0_cyc ? 0 : -1;
            end
            if (nxt_owner != owner || !(gcyc && gstb) || resp || tmo) stall = 0;
            else stall = stall + 1;
            owner = nxt_owner;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
